hsv_core_issue_scoreboard: RTL and testbench
============================================

// Module: hsv_core_issue_scoreboard
// PURPOSE
//   Register scoreboard and issue gate for the issue stage. Counts in-flight writes per architectural
//   register, sets on issue, clears on commit, and raises a RAW hazard that back-pressures issue.
//   On flush it blocks issue and drains until every issued instruction has retired.
//   Sits between decode/issue handshake and the issue muxing stage; provides its hazard/stall inputs.
// PARAMETERS
//   NUM_REGS      32  architectural registers; bit 0 (x0) is never tracked
//   CNT_W         2   per-register counter width; max 2**CNT_W-1 outstanding writes per register
//   MAX_INFLIGHT  8   max total issued-but-not-retired instructions (power of two not required)
// PORTS
//   clk_core        in   1                     core clock, all state on rising edge
//   rst_core        in   1                     asynchronous, active-high reset
//   issue_valid     in   1                     upstream has an instruction to issue
//   issue_ready     out  1                     scoreboard accepts it this cycle
//   issue_rs_mask   in   NUM_REGS              source registers read by instruction
//   issue_rd_mask   in   NUM_REGS              destination register, one-hot or zero
//   commit_valid    in   1                     one instruction retires (incl. squashed ones)
//   commit_rd_mask  in   NUM_REGS              its destination, one-hot or zero (same as issued)
//   flush_req       in   1                     pipeline flush
//   hazard          out  1                     RAW hazard on issue_rs_mask
//   pending_mask    out  NUM_REGS              bit i = counter[i] != 0
//   inflight        out  $clog2(MAX_INFLIGHT+1) issued-not-retired count
//   draining        out  1                     FSM in DRAIN
//   sb_error        out  1                     sticky: commit underflow or count overflow seen
// BEHAVIOUR
//   Reset: all counters 0, inflight 0, FSM RUN, sb_error 0; outputs derive from these (issue_ready
//     then = ~flush_req, hazard 0, pending_mask 0, draining 0).
//   hazard = |(issue_rs_mask & pending_mask), bit 0 masked. Combinational, zero latency.
//   issue_ready = state==RUN & ~flush_req & ~hazard & inflight<MAX_INFLIGHT
//     & ~(rd counter saturated). Fire = issue_valid & issue_ready.
//   Fire: inflight+1; counter[rd]+1 (no change if rd_mask==0 or rd==x0). Updates visible next cycle.
//   Commit: inflight-1; counter[rd]-1. Same-cycle fire+commit: net update per counter/inflight
//     (+1-1 = unchanged on same register).
//   Underflow (commit with counter or inflight already 0): no decrement, sb_error<=1 and held until reset.
//   Non-one-hot rd mask: behaviour undefined; bench asserts $onehot0.
//   FSM RUN: flush_req -> DRAIN (issue blocked the same cycle via ~flush_req term).
//   FSM DRAIN: issue_ready=0; commits keep decrementing; when inflight==0 (registered) -> RUN.
//     flush_req while in DRAIN: stay in DRAIN. flush_req while inflight==0 in RUN: one DRAIN cycle, then RUN.
//   Counters stay self-consistent through a flush: squashed instructions still commit (no RF write)
//     so all counters reach 0 when DRAIN exits; DRAIN exit with any counter!=0 sets sb_error.
//   Reset mid-drain: immediate return to reset state, no pending commits honoured.
// CONFIGURATION
//   HSV_ISSUE_SB_BYPASS_EN defined: commit-to-issue bypass; a register whose counter==1 and is
//     committing this cycle is excluded from hazard and saturation checks (issue same cycle).
//   Undefined: hazard/saturation use registered counters only; dependent issue occurs one cycle after commit.
// TESTING
//   Issue rd=x5; next cycle rs=x5 -> hazard=1, issue_ready=0; commit x5 -> hazard=0 next cycle (same cycle with BYPASS_EN).
//   Issue rd=x0 then rs=x0 -> hazard=0, pending_mask=0, inflight=1.
//   CNT_W=2: three issues rd=x7 accepted, fourth held ready=0 until a commit x7; same-cycle issue+commit x7 keeps counter 3.
//   MAX_INFLIGHT=8: 8 issues to distinct rd, 9th ready=0; one commit -> ready=1 next cycle.
//   4 in flight, flush_req -> draining=1, ready=0 for 4 commit cycles, RUN and ready=1 the cycle after inflight==0.
//   Commit with inflight==0 -> sb_error=1, inflight stays 0; async rst_core mid-DRAIN clears all state immediately.

Source files
------------

// File: rtl/hsv_core_issue_scoreboard.sv
// Purpose : register scoreboard and issue gate for the issue stage. It counts in-flight
//           writes per architectural register and raises a RAW hazard that stalls issue.
//           On flush it blocks issue and drains until everything issued has retired.
// Latency : hazard/issue_ready are combinational (zero latency). Counter, inflight, FSM
//           and sb_error updates are visible the cycle after the issue/commit edge.
// Backpressure: issue_ready drops on a hazard, on a saturated destination counter, when
//           inflight reaches MAX_INFLIGHT, while flush_req is high and while draining.
//           Commits are never back-pressured.
//
// Ports:
//   clk_core, rst_core           clock; asynchronous active-high reset
//   issue_valid / issue_ready    issue handshake; fire = issue_valid & issue_ready
//   issue_rs_mask, issue_rd_mask source registers read, destination (one-hot or zero)
//   commit_valid, commit_rd_mask one retirement per cycle, destination as issued
//   flush_req                    pipeline flush request
//   hazard                       RAW hazard on issue_rs_mask
//   pending_mask                 bit i set while register i has outstanding writes
//   inflight                     issued-but-not-retired count
//   draining                     FSM is in DRAIN
//   sb_error                     sticky: commit underflow, counter overflow, or dirty drain exit
//
// Build option: define HSV_ISSUE_SB_BYPASS_EN to let a register whose last outstanding
//   write commits this cycle stop blocking issue in that same cycle.

module hsv_core_issue_scoreboard #(
  parameter  int NUM_REGS     = 32,
  parameter  int CNT_W        = 2,
  parameter  int MAX_INFLIGHT = 8,
  localparam int INF_W        = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic                clk_core,
  input  logic                rst_core,
  input  logic                issue_valid,
  output logic                issue_ready,
  input  logic [NUM_REGS-1:0] issue_rs_mask,
  input  logic [NUM_REGS-1:0] issue_rd_mask,
  input  logic                commit_valid,
  input  logic [NUM_REGS-1:0] commit_rd_mask,
  input  logic                flush_req,
  output logic                hazard,
  output logic [NUM_REGS-1:0] pending_mask,
  output logic [INF_W-1:0]    inflight,
  output logic                draining,
  output logic                sb_error
);

  typedef enum logic [0:0] {
    S_RUN   = 1'b0,
    S_DRAIN = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [INF_W-1:0] INF_ONE = INF_W'(1);
  localparam logic [INF_W-1:0] INF_MAX = INF_W'(MAX_INFLIGHT);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t           r_state;
  state_t           w_state_nxt;
  logic [INF_W-1:0] r_inflight;
  logic             r_sb_error;

  // ---------------------------------------------------------------------------
  // Per-register status vectors
  // ---------------------------------------------------------------------------
  logic                w_fire;
  logic [NUM_REGS-1:0] w_pending;   // counter != 0
  logic [NUM_REGS-1:0] w_sat;       // counter at its maximum
  logic [NUM_REGS-1:0] w_cnt_unf;   // commit against a zero counter
  logic [NUM_REGS-1:0] w_cnt_ovf;   // increment that would wrap the counter
  logic [NUM_REGS-1:0] w_block;     // registers that still block a reader
  logic [NUM_REGS-1:0] w_sat_eff;   // registers that still block a writer
`ifdef HSV_ISSUE_SB_BYPASS_EN
  logic [NUM_REGS-1:0] w_bypass;    // last outstanding write retiring this cycle
`endif

  genvar g;
  generate
    for (g = 0; g < NUM_REGS; g++) begin : g_reg
      // x0 is hard-wired to zero, so its counter never moves and never flags errors.
      localparam bit TRACKED = (g != 0);

      logic [CNT_W-1:0] r_cnt;
      logic             w_inc;
      logic             w_dec_req;
      logic             w_dec;

      assign w_inc     = TRACKED & w_fire & issue_rd_mask[g];
      assign w_dec_req = TRACKED & commit_valid & commit_rd_mask[g];
      // A commit against an empty counter is an error and must not wrap it.
      assign w_dec     = w_dec_req & (r_cnt != '0);

      always_ff @(posedge clk_core or posedge rst_core) begin
        if (rst_core) begin
          r_cnt <= '0;
        end else if (w_inc & ~w_dec & (r_cnt != CNT_MAX)) begin
          r_cnt <= r_cnt + CNT_ONE;
        end else if (w_dec & ~w_inc) begin
          r_cnt <= r_cnt - CNT_ONE;
        end
      end

      assign w_pending[g] = (r_cnt != '0);
      assign w_sat[g]     = (r_cnt == CNT_MAX);
      assign w_cnt_unf[g] = w_dec_req & (r_cnt == '0);
      assign w_cnt_ovf[g] = w_inc & ~w_dec & (r_cnt == CNT_MAX);
`ifdef HSV_ISSUE_SB_BYPASS_EN
      assign w_bypass[g]  = w_dec_req & (r_cnt == CNT_ONE);
`endif
    end
  endgenerate

`ifdef HSV_ISSUE_SB_BYPASS_EN
  // The retiring write frees the register at the same edge the new instruction
  // issues, so it need not wait for the registered counter to reach zero.
  assign w_block   = w_pending & ~w_bypass;
  assign w_sat_eff = w_sat & ~w_bypass;
`else
  assign w_block   = w_pending;
  assign w_sat_eff = w_sat;
`endif

  // ---------------------------------------------------------------------------
  // Issue gate
  // ---------------------------------------------------------------------------
  logic w_hazard;
  logic w_rd_sat;
  logic w_inflight_full;

  assign w_hazard        = |(issue_rs_mask & w_block);
  assign w_rd_sat        = |(issue_rd_mask & w_sat_eff);
  assign w_inflight_full = (r_inflight >= INF_MAX);

  assign issue_ready = (r_state == S_RUN) & ~flush_req & ~w_hazard
                     & ~w_inflight_full & ~w_rd_sat;
  assign w_fire      = issue_valid & issue_ready;

  // ---------------------------------------------------------------------------
  // Inflight counter: fire and commit in one cycle cancel out.
  // ---------------------------------------------------------------------------
  logic w_inf_dec;
  logic w_inf_unf;
  logic w_inf_ovf;

  assign w_inf_dec = commit_valid & (r_inflight != '0);
  assign w_inf_unf = commit_valid & (r_inflight == '0);
  assign w_inf_ovf = w_fire & ~w_inf_dec & (r_inflight == INF_MAX);

  always_ff @(posedge clk_core or posedge rst_core) begin
    if (rst_core) begin
      r_inflight <= '0;
    end else if (w_fire & ~w_inf_dec & ~w_inf_ovf) begin
      r_inflight <= r_inflight + INF_ONE;
    end else if (w_inf_dec & ~w_fire) begin
      r_inflight <= r_inflight - INF_ONE;
    end
  end

  // ---------------------------------------------------------------------------
  // Flush FSM
  // ---------------------------------------------------------------------------
  logic w_drain_exit;

  always_ff @(posedge clk_core or posedge rst_core) begin
    if (rst_core) begin
      r_state <= S_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_drain_exit = 1'b0;
    case (r_state)
      S_RUN: begin
        if (flush_req) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Exit on the registered count so the last commit is fully absorbed
        // before issue reopens; a repeated flush keeps us here.
        if (!flush_req && (r_inflight == '0)) begin
          w_state_nxt  = S_RUN;
          w_drain_exit = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_RUN;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Sticky error: every squashed instruction still commits, so all counters
  // must be empty by the time the drain completes.
  // ---------------------------------------------------------------------------
  logic w_err_set;

  assign w_err_set = (|w_cnt_unf) | (|w_cnt_ovf) | w_inf_unf | w_inf_ovf
                   | (w_drain_exit & (|w_pending));

  always_ff @(posedge clk_core or posedge rst_core) begin
    if (rst_core) begin
      r_sb_error <= 1'b0;
    end else if (w_err_set) begin
      r_sb_error <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign hazard       = w_hazard;
  assign pending_mask = w_pending;
  assign inflight     = r_inflight;
  assign draining     = (r_state == S_DRAIN);
  assign sb_error     = r_sb_error;

endmodule

// File: tb/tb_hsv_core_issue_scoreboard.sv
// Directed bench for hsv_core_issue_scoreboard (default parameters).
// Inputs change 1ns after a rising edge; outputs are sampled 1ns after that.
// Expectations that differ with HSV_ISSUE_SB_BYPASS_EN follow the BYP flag.

module tb_hsv_core_issue_scoreboard;

`ifdef HSV_ISSUE_SB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  localparam logic [31:0] X0 = 32'h0000_0001;
  localparam logic [31:0] X3 = 32'h0000_0008;
  localparam logic [31:0] X5 = 32'h0000_0020;
  localparam logic [31:0] X7 = 32'h0000_0080;

  logic        clk_core = 1'b0;
  logic        rst_core;
  logic        issue_valid;
  logic        issue_ready;
  logic [31:0] issue_rs_mask;
  logic [31:0] issue_rd_mask;
  logic        commit_valid;
  logic [31:0] commit_rd_mask;
  logic        flush_req;
  logic        hazard;
  logic [31:0] pending_mask;
  logic [3:0]  inflight;
  logic        draining;
  logic        sb_error;

  int n_vec = 0;
  int n_err = 0;

  hsv_core_issue_scoreboard dut (
    .clk_core       (clk_core),
    .rst_core       (rst_core),
    .issue_valid    (issue_valid),
    .issue_ready    (issue_ready),
    .issue_rs_mask  (issue_rs_mask),
    .issue_rd_mask  (issue_rd_mask),
    .commit_valid   (commit_valid),
    .commit_rd_mask (commit_rd_mask),
    .flush_req      (flush_req),
    .hazard         (hazard),
    .pending_mask   (pending_mask),
    .inflight       (inflight),
    .draining       (draining),
    .sb_error       (sb_error)
  );

  always #5 clk_core = ~clk_core;

  // Destination masks must be one-hot or zero.
  always @(posedge clk_core) begin
    if (!rst_core) begin
      assert ($onehot0(issue_rd_mask));
      assert ($onehot0(commit_rd_mask));
    end
  end

  task automatic step();
    @(posedge clk_core);
    #1;
  endtask

  task automatic clr();
    issue_valid    = 1'b0;
    issue_rs_mask  = '0;
    issue_rd_mask  = '0;
    commit_valid   = 1'b0;
    commit_rd_mask = '0;
    flush_req      = 1'b0;
  endtask

  task automatic test_reset();
    rst_core = 1'b1;
    clr();
    #2;
    n_vec++; if (issue_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b exp 1", issue_ready); end
    n_vec++; if (hazard !== 1'b0) begin n_err++; $display("FAIL reset_hazard: got %b exp 0", hazard); end
    n_vec++; if (pending_mask !== 32'h0) begin n_err++; $display("FAIL reset_pending: got %h exp 0", pending_mask); end
    n_vec++; if (inflight !== 4'd0) begin n_err++; $display("FAIL reset_inflight: got %0d exp 0", inflight); end
    n_vec++; if (draining !== 1'b0) begin n_err++; $display("FAIL reset_draining: got %b exp 0", draining); end
    n_vec++; if (sb_error !== 1'b0) begin n_err++; $display("FAIL reset_sb_error: got %b exp 0", sb_error); end
    flush_req = 1'b1;
    #1;
    n_vec++; if (issue_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready_flush: got %b exp 0", issue_ready); end
    flush_req = 1'b0;
    #1;
    rst_core = 1'b0;
    step();
  endtask

  task automatic test_raw_hazard();
    clr();
    issue_valid = 1'b1; issue_rd_mask = X5;
    #1;
    n_vec++; if (issue_ready !== 1'b1) begin n_err++; $display("FAIL raw_first_ready: got %b exp 1", issue_ready); end
    step();
    issue_rd_mask = '0; issue_rs_mask = X5;
    #1;
    n_vec++; if (hazard !== 1'b1) begin n_err++; $display("FAIL raw_hazard: got %b exp 1", hazard); end
    n_vec++; if (issue_ready !== 1'b0) begin n_err++; $display("FAIL raw_ready: got %b exp 0", issue_ready); end
    n_vec++; if (pending_mask !== X5) begin n_err++; $display("FAIL raw_pending: got %h exp %h", pending_mask, X5); end
    n_vec++; if (inflight !== 4'd1) begin n_err++; $display("FAIL raw_inflight: got %0d exp 1", inflight); end
    issue_valid = 1'b0;
    commit_valid = 1'b1; commit_rd_mask = X5;
    #1;
    n_vec++; if (hazard !== !BYP) begin n_err++; $display("FAIL raw_commit_cycle_hazard: got %b exp %b", hazard, !BYP); end
    n_vec++; if (issue_ready !== BYP) begin n_err++; $display("FAIL raw_commit_cycle_ready: got %b exp %b", issue_ready, BYP); end
    step();
    commit_valid = 1'b0; commit_rd_mask = '0;
    #1;
    n_vec++; if (hazard !== 1'b0) begin n_err++; $display("FAIL raw_after_commit_hazard: got %b exp 0", hazard); end
    n_vec++; if (issue_ready !== 1'b1) begin n_err++; $display("FAIL raw_after_commit_ready: got %b exp 1", issue_ready); end
    n_vec++; if (pending_mask !== 32'h0) begin n_err++; $display("FAIL raw_after_commit_pending: got %h exp 0", pending_mask); end
    n_vec++; if (inflight !== 4'd0) begin n_err++; $display("FAIL raw_after_commit_inflight: got %0d exp 0", inflight); end
    step();
  endtask

  task automatic test_x0();
    clr();
    issue_valid = 1'b1; issue_rd_mask = X0;
    #1;
    n_vec++; if (issue_ready !== 1'b1) begin n_err++; $display("FAIL x0_ready: got %b exp 1", issue_ready); end
    step();
    issue_valid = 1'b0; issue_rd_mask = '0; issue_rs_mask = X0;
    #1;
    n_vec++; if (hazard !== 1'b0) begin n_err++; $display("FAIL x0_hazard: got %b exp 0", hazard); end
    n_vec++; if (pending_mask !== 32'h0) begin n_err++; $display("FAIL x0_pending: got %h exp 0", pending_mask); end
    n_vec++; if (inflight !== 4'd1) begin n_err++; $display("FAIL x0_inflight: got %0d exp 1", inflight); end
    commit_valid = 1'b1; commit_rd_mask = X0;
    step();
    commit_valid = 1'b0; commit_rd_mask = '0;
    #1;
    n_vec++; if (inflight !== 4'd0) begin n_err++; $display("FAIL x0_commit_inflight: got %0d exp 0", inflight); end
    n_vec++; if (sb_error !== 1'b0) begin n_err++; $display("FAIL x0_commit_sb_error: got %b exp 0", sb_error); end
    step();
  endtask

  task automatic test_saturation();
    clr();
    issue_valid = 1'b1; issue_rd_mask = X7;
    #1;
    n_vec++; if (issue_ready !== 1'b1) begin n_err++; $display("FAIL sat_first_ready: got %b exp 1", issue_ready); end
    step(); step(); step();
    n_vec++; if (issue_ready !== 1'b0) begin n_err++; $display("FAIL sat_fourth_ready: got %b exp 0", issue_ready); end
    n_vec++; if (inflight !== 4'd3) begin n_err++; $display("FAIL sat_inflight3: got %0d exp 3", inflight); end
    n_vec++; if (pending_mask !== X7) begin n_err++; $display("FAIL sat_pending: got %h exp %h", pending_mask, X7); end
    step();
    n_vec++; if (inflight !== 4'd3) begin n_err++; $display("FAIL sat_held_inflight: got %0d exp 3", inflight); end
    commit_valid = 1'b1; commit_rd_mask = X7;
    #1;
    n_vec++; if (issue_ready !== 1'b0) begin n_err++; $display("FAIL sat_commit_cycle_ready: got %b exp 0", issue_ready); end
    step();
    // counter now 2: issue and commit x7 together leaves it at 2
    n_vec++; if (issue_ready !== 1'b1) begin n_err++; $display("FAIL sat_after_commit_ready: got %b exp 1", issue_ready); end
    step();
    commit_valid = 1'b0; commit_rd_mask = '0;
    #1;
    n_vec++; if (inflight !== 4'd2) begin n_err++; $display("FAIL sat_net_inflight: got %0d exp 2", inflight); end
    n_vec++; if (issue_ready !== 1'b1) begin n_err++; $display("FAIL sat_net_ready: got %b exp 1", issue_ready); end
    step();
    n_vec++; if (issue_ready !== 1'b0) begin n_err++; $display("FAIL sat_refill_ready: got %b exp 0", issue_ready); end
    n_vec++; if (inflight !== 4'd3) begin n_err++; $display("FAIL sat_refill_inflight: got %0d exp 3", inflight); end
    issue_valid = 1'b0; issue_rd_mask = '0;
    commit_valid = 1'b1; commit_rd_mask = X7;
    step(); step();
    n_vec++; if (pending_mask !== X7) begin n_err++; $display("FAIL sat_drain2_pending: got %h exp %h", pending_mask, X7); end
    n_vec++; if (inflight !== 4'd1) begin n_err++; $display("FAIL sat_drain2_inflight: got %0d exp 1", inflight); end
    step();
    commit_valid = 1'b0; commit_rd_mask = '0;
    #1;
    n_vec++; if (pending_mask !== 32'h0) begin n_err++; $display("FAIL sat_drain3_pending: got %h exp 0", pending_mask); end
    n_vec++; if (inflight !== 4'd0) begin n_err++; $display("FAIL sat_drain3_inflight: got %0d exp 0", inflight); end
    step();
  endtask

  task automatic test_max_inflight();
    clr();
    for (int i = 1; i <= 8; i++) begin
      issue_valid = 1'b1; issue_rd_mask = 32'd1 << i;
      #1;
      n_vec++; if (issue_ready !== 1'b1) begin n_err++; $display("FAIL max_fill_ready[%0d]: got %b exp 1", i, issue_ready); end
      step();
    end
    issue_rd_mask = 32'd1 << 9;
    #1;
    n_vec++; if (issue_ready !== 1'b0) begin n_err++; $display("FAIL max_ninth_ready: got %b exp 0", issue_ready); end
    n_vec++; if (inflight !== 4'd8) begin n_err++; $display("FAIL max_inflight8: got %0d exp 8", inflight); end
    n_vec++; if (pending_mask !== 32'h0000_01fe) begin n_err++; $display("FAIL max_pending: got %h exp 000001fe", pending_mask); end
    commit_valid = 1'b1; commit_rd_mask = 32'd1 << 1;
    #1;
    n_vec++; if (issue_ready !== 1'b0) begin n_err++; $display("FAIL max_commit_cycle_ready: got %b exp 0", issue_ready); end
    step();
    commit_valid = 1'b0; commit_rd_mask = '0;
    #1;
    n_vec++; if (issue_ready !== 1'b1) begin n_err++; $display("FAIL max_after_commit_ready: got %b exp 1", issue_ready); end
    issue_valid = 1'b0; issue_rd_mask = '0;
    for (int i = 2; i <= 8; i++) begin
      commit_valid = 1'b1; commit_rd_mask = 32'd1 << i;
      step();
    end
    clr();
    #1;
    n_vec++; if (inflight !== 4'd0) begin n_err++; $display("FAIL max_drained_inflight: got %0d exp 0", inflight); end
    n_vec++; if (pending_mask !== 32'h0) begin n_err++; $display("FAIL max_drained_pending: got %h exp 0", pending_mask); end
    step();
  endtask

  task automatic test_flush_drain();
    clr();
    for (int i = 10; i <= 13; i++) begin
      issue_valid = 1'b1; issue_rd_mask = 32'd1 << i;
      step();
    end
    issue_valid = 1'b0; issue_rd_mask = '0; flush_req = 1'b1;
    #1;
    n_vec++; if (issue_ready !== 1'b0) begin n_err++; $display("FAIL flush_cycle_ready: got %b exp 0", issue_ready); end
    n_vec++; if (inflight !== 4'd4) begin n_err++; $display("FAIL flush_inflight4: got %0d exp 4", inflight); end
    n_vec++; if (draining !== 1'b0) begin n_err++; $display("FAIL flush_cycle_draining: got %b exp 0", draining); end
    step();
    flush_req = 1'b0; issue_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      commit_valid = 1'b1; commit_rd_mask = 32'd1 << (10 + k);
      #1;
      n_vec++; if (draining !== 1'b1) begin n_err++; $display("FAIL drain_draining[%0d]: got %b exp 1", k, draining); end
      n_vec++; if (issue_ready !== 1'b0) begin n_err++; $display("FAIL drain_ready[%0d]: got %b exp 0", k, issue_ready); end
      step();
    end
    commit_valid = 1'b0; commit_rd_mask = '0;
    #1;
    n_vec++; if (inflight !== 4'd0) begin n_err++; $display("FAIL drain_empty_inflight: got %0d exp 0", inflight); end
    n_vec++; if (draining !== 1'b1) begin n_err++; $display("FAIL drain_empty_draining: got %b exp 1", draining); end
    n_vec++; if (issue_ready !== 1'b0) begin n_err++; $display("FAIL drain_empty_ready: got %b exp 0", issue_ready); end
    n_vec++; if (pending_mask !== 32'h0) begin n_err++; $display("FAIL drain_empty_pending: got %h exp 0", pending_mask); end
    step();
    n_vec++; if (draining !== 1'b0) begin n_err++; $display("FAIL drain_exit_draining: got %b exp 0", draining); end
    n_vec++; if (issue_ready !== 1'b1) begin n_err++; $display("FAIL drain_exit_ready: got %b exp 1", issue_ready); end
    n_vec++; if (sb_error !== 1'b0) begin n_err++; $display("FAIL drain_exit_sb_error: got %b exp 0", sb_error); end
    clr();
    step();
  endtask

  task automatic test_flush_idle();
    clr();
    flush_req = 1'b1;
    #1;
    n_vec++; if (issue_ready !== 1'b0) begin n_err++; $display("FAIL idle_flush_ready: got %b exp 0", issue_ready); end
    step();
    n_vec++; if (draining !== 1'b1) begin n_err++; $display("FAIL idle_flush_draining: got %b exp 1", draining); end
    step();
    // flush held in DRAIN keeps the FSM there
    flush_req = 1'b0;
    #1;
    n_vec++; if (draining !== 1'b1) begin n_err++; $display("FAIL idle_flush_hold: got %b exp 1", draining); end
    step();
    n_vec++; if (draining !== 1'b0) begin n_err++; $display("FAIL idle_flush_exit: got %b exp 0", draining); end
    n_vec++; if (issue_ready !== 1'b1) begin n_err++; $display("FAIL idle_flush_exit_ready: got %b exp 1", issue_ready); end
    step();
  endtask

  task automatic test_underflow();
    clr();
    commit_valid = 1'b1; commit_rd_mask = X3;
    #1;
    n_vec++; if (sb_error !== 1'b0) begin n_err++; $display("FAIL unf_before: got %b exp 0", sb_error); end
    step();
    clr();
    #1;
    n_vec++; if (sb_error !== 1'b1) begin n_err++; $display("FAIL unf_sb_error: got %b exp 1", sb_error); end
    n_vec++; if (inflight !== 4'd0) begin n_err++; $display("FAIL unf_inflight: got %0d exp 0", inflight); end
    n_vec++; if (pending_mask !== 32'h0) begin n_err++; $display("FAIL unf_pending: got %h exp 0", pending_mask); end
    step(); step();
    n_vec++; if (sb_error !== 1'b1) begin n_err++; $display("FAIL unf_sticky: got %b exp 1", sb_error); end
  endtask

  task automatic test_reset_mid_drain();
    clr();
    issue_valid = 1'b1; issue_rd_mask = 32'd1 << 20;
    step();
    issue_rd_mask = 32'd1 << 21;
    step();
    issue_valid = 1'b0; issue_rd_mask = '0; flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    #1;
    n_vec++; if (draining !== 1'b1) begin n_err++; $display("FAIL rstdrain_draining: got %b exp 1", draining); end
    n_vec++; if (inflight !== 4'd2) begin n_err++; $display("FAIL rstdrain_inflight: got %0d exp 2", inflight); end
    rst_core = 1'b1;
    #1;
    n_vec++; if (draining !== 1'b0) begin n_err++; $display("FAIL rstdrain_async_draining: got %b exp 0", draining); end
    n_vec++; if (inflight !== 4'd0) begin n_err++; $display("FAIL rstdrain_async_inflight: got %0d exp 0", inflight); end
    n_vec++; if (pending_mask !== 32'h0) begin n_err++; $display("FAIL rstdrain_async_pending: got %h exp 0", pending_mask); end
    n_vec++; if (sb_error !== 1'b0) begin n_err++; $display("FAIL rstdrain_async_sb_error: got %b exp 0", sb_error); end
    n_vec++; if (issue_ready !== 1'b1) begin n_err++; $display("FAIL rstdrain_async_ready: got %b exp 1", issue_ready); end
    #3;
    rst_core = 1'b0;
    step();
    n_vec++; if (draining !== 1'b0) begin n_err++; $display("FAIL rstdrain_after_draining: got %b exp 0", draining); end
    n_vec++; if (issue_ready !== 1'b1) begin n_err++; $display("FAIL rstdrain_after_ready: got %b exp 1", issue_ready); end
  endtask

  initial begin
    test_reset();
    test_raw_hazard();
    test_x0();
    test_saturation();
    test_max_inflight();
    test_flush_drain();
    test_flush_idle();
    test_underflow();
    test_reset_mid_drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
